// File: rtl/crc_pkg.sv
// crc_pkg: shared constants, FSM state type and CRC helper functions for
// the streaming CRC engine.
//   CRC32_POLY / CRC32_INIT / CRC32_XOROUT : standard CRC-32 parameters
//   crc_state_t                            : engine FSM states
//   reflect32      : 32-bit bit reversal (bit 0 <-> bit 31)
//   crc_byte_step  : one 8-bit MSB-first LFSR step of a normal-form register
package crc_pkg;

  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } crc_state_t;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [7:0] reflect8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

  // The register is always kept in normal (MSB-first) form; a reflected
  // input stream is handled by bit-reversing each byte before it enters.
  function automatic logic [31:0] crc_byte_step(
    input logic [31:0] crc,
    input logic [7:0]  data_byte,
    input logic [31:0] poly,
    input logic        reflect_in
  );
    logic [7:0]  b;
    logic [31:0] r;
    b = reflect_in ? reflect8(data_byte) : data_byte;
    r = crc ^ {b, 24'h000000};
    for (int i = 0; i < 8; i++) begin
      r = r[31] ? ((r << 1) ^ poly) : (r << 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_word_step.sv
// crc_word_step: combinational beat update. Chains DATA_W/8 byte steps
// starting from crcIn, byte 0 (data[7:0]) first, and exposes every
// intermediate result.
//   crcIn    : current CRC register
//   data     : beat data
//   crcCand  : crcCand[k] = register after processing bytes 0..k
module crc_word_step
  import crc_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter logic [31:0] POLY       = CRC32_POLY,
  parameter bit          REFLECT_IN = 1'b1
) (
  input  logic [31:0]               crcIn,
  input  logic [DATA_W-1:0]         data,
  output logic [DATA_W/8-1:0][31:0] crcCand
);

  localparam int NB = DATA_W / 8;

  // Byte-serial chain; each tap is a candidate for a partial last beat.
  always_comb begin
    logic [31:0] acc;
    acc = crcIn;
    for (int k = 0; k < NB; k++) begin
      acc        = crc_byte_step(acc, data[8*k +: 8], POLY, REFLECT_IN);
      crcCand[k] = acc;
    end
  end

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: framed streaming CRC with valid/ready in and out.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a frame (loads INIT)
//   inValid/inReady   : input beat handshake
//   inData/inKeep     : beat data, byte-keep mask (last beat only)
//   inLast            : final beat of the frame
//   outValid/outReady : result handshake
//   crcOut            : finalised CRC, held while outValid
//   busy              : engine not idle
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter logic [31:0] POLY        = CRC32_POLY,
  parameter logic [31:0] INIT        = CRC32_INIT,
  parameter logic [31:0] XOR_OUT     = CRC32_XOROUT,
  parameter bit          REFLECT_IN  = 1'b1,
  parameter bit          REFLECT_OUT = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                inValid,
  output logic                inReady,
  input  logic [DATA_W-1:0]   inData,
  input  logic [DATA_W/8-1:0] inKeep,
  input  logic                inLast,
  output logic                outValid,
  input  logic                outReady,
  output logic [31:0]         crcOut,
  output logic                busy
);

  localparam int NB = DATA_W / 8;
  localparam int KW = $clog2(NB + 1);

  crc_state_t          state_q, state_d;
  logic [31:0]         crc_q, crc_d;
  logic [31:0]         crc_out_q, crc_out_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic [NB-1:0][31:0] cand_s;
  logic [KW-1:0]       keep_cnt_s;
  logic [31:0]         beat_crc_s;
  logic                beat_acc_s;

  function automatic logic [31:0] finalize_crc(input logic [31:0] r);
    return (REFLECT_OUT ? reflect32(r) : r) ^ XOR_OUT;
  endfunction

  crc_word_step #(
    .DATA_W    (DATA_W),
    .POLY      (POLY),
    .REFLECT_IN(REFLECT_IN)
  ) u_word_step (
    .crcIn  (crc_q),
    .data   (inData),
    .crcCand(cand_s)
  );

  // start wins over a simultaneous beat, so it masks ready.
  assign inReady    = (state_q == RUN) && !start;
  assign beat_acc_s = inValid && inReady;
  assign outValid   = out_valid_q;
  assign crcOut     = crc_out_q;
  assign busy       = busy_q;

  // Popcount of the keep mask; contiguity is the producer's obligation.
  always_comb begin
    keep_cnt_s = '0;
    for (int i = 0; i < NB; i++) begin
      keep_cnt_s = keep_cnt_s + KW'(inKeep[i]);
    end
  end

  // Pick the register value after this beat: full beat, or N kept bytes on
  // the last beat (N = 0 leaves the register untouched).
  always_comb begin
    beat_crc_s = cand_s[NB-1];
    if (inLast) begin
      beat_crc_s = crc_q;
      for (int k = 1; k <= NB; k++) begin
        beat_crc_s = (int'(keep_cnt_s) == k) ? cand_s[k-1] : beat_crc_s;
      end
    end else begin
      beat_crc_s = cand_s[NB-1];
    end
  end

  // Next-state, CRC register and result register logic.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    crc_out_d   = crc_out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          crc_d   = INIT;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (start) begin
          crc_d = INIT;
        end else if (beat_acc_s) begin
          crc_d = beat_crc_s;
          if (inLast) begin
            state_d     = DONE;
            crc_out_d   = finalize_crc(beat_crc_s);
            out_valid_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (outReady) begin
          out_valid_d = 1'b0;
          if (start) begin
            state_d = RUN;
            crc_d   = INIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      crc_out_q   <= 32'h00000000;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      crc_out_q   <= crc_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench: two 32-bit engines (CRC-32 and CRC-32/MPEG-2) share
// one stimulus stream; an 8-bit CRC-32 engine runs its own stream. Results
// are compared against bitwise reference CRCs computed from the byte queue.
module tb_crc_stream_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start32, inValid32, inLast32, outReady32;
  logic [31:0] inData32;
  logic [3:0]  inKeep32;
  logic        inReady32, outValid32, busy32;
  logic        inReadyM, outValidM, busyM;
  logic [31:0] crc32, crcM;
  logic        start8, inValid8, inLast8, outReady8;
  logic [7:0]  inData8;
  logic [0:0]  inKeep8;
  logic        inReady8, outValid8, busy8;
  logic [31:0] crc8;

  int checks   = 0;
  int failures = 0;
  logic [7:0] frame_q[$];

  crc_stream_engine u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .inValid(inValid32), .inReady(inReady32),
    .inData(inData32), .inKeep(inKeep32), .inLast(inLast32), .outValid(outValid32),
    .outReady(outReady32), .crcOut(crc32), .busy(busy32)
  );

  crc_stream_engine #(
    .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .XOR_OUT(32'h00000000)
  ) u_mpeg (
    .clk(clk), .rst(rst), .start(start32), .inValid(inValid32), .inReady(inReadyM),
    .inData(inData32), .inKeep(inKeep32), .inLast(inLast32), .outValid(outValidM),
    .outReady(outReady32), .crcOut(crcM), .busy(busyM)
  );

  crc_stream_engine #(.DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .inValid(inValid8), .inReady(inReady8),
    .inData(inData8), .inKeep(inKeep8), .inLast(inLast8), .outValid(outValid8),
    .outReady(outReady8), .crcOut(crc8), .busy(busy8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Classic LSB-first CRC-32 with the reversed polynomial.
  function automatic logic [31:0] model_crc32();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frame_q[i]) begin
      c = c ^ {24'd0, frame_q[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // CRC-32/MPEG-2: MSB-first, no reflection, no final XOR.
  function automatic logic [31:0] model_mpeg2();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (frame_q[i]) begin
      c = c ^ {frame_q[i], 24'd0};
      for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c;
  endfunction

  task automatic set_check_frame();
    frame_q.delete();
    for (int i = 0; i < 9; i++) frame_q.push_back(8'h31 + 8'(i));
  endtask

  task automatic set_random_frame(input int max_len);
    int len;
    frame_q.delete();
    len = $urandom_range(0, max_len);
    for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
  endtask

  // ---------------- 32-bit stream ----------------
  task automatic start32_cycle(input bit with_beat);
    start32 = 1'b1; inValid32 = with_beat; inLast32 = with_beat;
    inData32 = $urandom; inKeep32 = 4'hF;
    #1 check_eq("rdy32_at_start", 32'(inReady32), 32'd0);
    @(negedge clk);
    start32 = 1'b0; inValid32 = 1'b0; inLast32 = 1'b0;
    check_eq("busy32_after_start", 32'(busy32), 32'd1);
    check_eq("ov32_after_start", 32'(outValid32), 32'd0);
  endtask

  task automatic partial32(input int n);
    for (int b = 0; b < n; b++) begin
      inValid32 = 1'b1; inLast32 = 1'b0; inData32 = $urandom; inKeep32 = 4'hF;
      #1 check_eq("rdy32_partial", 32'(inReady32), 32'd1);
      @(negedge clk);
    end
    inValid32 = 1'b0;
  endtask

  task automatic beats32();
    int len, nb, rem, idx;
    logic [31:0] w;
    len = frame_q.size();
    nb  = (len == 0) ? 1 : (len + 3) / 4;
    rem = len - 4 * (nb - 1);
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        inValid32 = 1'b0; inData32 = $urandom; inLast32 = 1'($urandom);
        @(negedge clk);
      end
      for (int k = 0; k < 4; k++) begin
        idx = 4 * b + k;
        w[8*k +: 8] = (idx < len) ? frame_q[idx] : 8'($urandom);
      end
      inData32 = w; inValid32 = 1'b1; inLast32 = (b == nb - 1);
      inKeep32 = (b == nb - 1) ? 4'((1 << rem) - 1) : 4'hF;
      #1 check_eq("rdy32_beat", 32'(inReady32), 32'd1);
      check_eq("ov32_during_frame", 32'(outValid32), 32'd0);
      @(negedge clk);
    end
    inValid32 = 1'b0; inLast32 = 1'b0;
    check_eq("ov32_result", 32'(outValid32), 32'd1);
    check_eq("ovM_result", 32'(outValidM), 32'd1);
    check_eq("crc32_model", crc32, model_crc32());
    check_eq("mpeg2_model", crcM, model_mpeg2());
  endtask

  task automatic drain32(input int hold, input bit with_start);
    outReady32 = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start32 = 1'($urandom);
      @(negedge clk);
      check_eq("ov32_hold", 32'(outValid32), 32'd1);
      check_eq("crc32_hold", crc32, model_crc32());
    end
    outReady32 = 1'b1; start32 = with_start;
    @(negedge clk);
    outReady32 = 1'b0; start32 = 1'b0;
    check_eq("ov32_after_take", 32'(outValid32), 32'd0);
    check_eq("busy32_after_take", 32'(busy32), 32'(with_start));
    check_eq("busyM_after_take", 32'(busyM), 32'(with_start));
    #1 check_eq("rdy32_after_take", 32'(inReady32), 32'(with_start));
  endtask

  // ---------------- 8-bit stream ----------------
  task automatic start8_cycle();
    start8 = 1'b1; inValid8 = 1'b0;
    #1 check_eq("rdy8_at_start", 32'(inReady8), 32'd0);
    @(negedge clk);
    start8 = 1'b0;
    check_eq("busy8_after_start", 32'(busy8), 32'd1);
  endtask

  task automatic beats8();
    int len, nb;
    len = frame_q.size();
    nb  = (len == 0) ? 1 : len;
    for (int b = 0; b < nb; b++) begin
      while ($urandom_range(0, 2) == 0) begin
        inValid8 = 1'b0; inData8 = 8'($urandom); inLast8 = 1'($urandom);
        @(negedge clk);
      end
      inData8  = (len == 0) ? 8'($urandom) : frame_q[b];
      inValid8 = 1'b1; inLast8 = (b == nb - 1);
      inKeep8  = (len == 0) ? 1'b0 : 1'b1;
      #1 check_eq("rdy8_beat", 32'(inReady8), 32'd1);
      check_eq("ov8_during_frame", 32'(outValid8), 32'd0);
      @(negedge clk);
    end
    inValid8 = 1'b0; inLast8 = 1'b0;
    check_eq("ov8_result", 32'(outValid8), 32'd1);
    check_eq("crc8_model", crc8, model_crc32());
  endtask

  task automatic drain8(input int hold);
    outReady8 = 1'b0;
    for (int i = 0; i < hold; i++) begin
      start8 = 1'($urandom);
      @(negedge clk);
      check_eq("ov8_hold", 32'(outValid8), 32'd1);
      check_eq("crc8_hold", crc8, model_crc32());
    end
    outReady8 = 1'b1; start8 = 1'b0;
    @(negedge clk);
    outReady8 = 1'b0;
    check_eq("ov8_after_take", 32'(outValid8), 32'd0);
    check_eq("busy8_after_take", 32'(busy8), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start32 = 1'b0; inValid32 = 1'b0; inLast32 = 1'b0; outReady32 = 1'b0;
    inData32 = 32'd0; inKeep32 = 4'd0;
    start8 = 1'b0; inValid8 = 1'b0; inLast8 = 1'b0; outReady8 = 1'b0;
    inData8 = 8'd0; inKeep8 = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_rdy32", 32'(inReady32), 32'd0);
    check_eq("reset_ov32", 32'(outValid32), 32'd0);
    check_eq("reset_crc32", crc32, 32'd0);
    check_eq("reset_busy32", 32'(busy32), 32'd0);
    check_eq("reset_ov8", 32'(outValid8), 32'd0);
    check_eq("reset_crc8", crc8, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_rdy32", 32'(inReady32), 32'd0);
    check_eq("idle_busy32", 32'(busy32), 32'd0);

    // "123456789", 3 beats, last keep = 0001
    set_check_frame();
    start32_cycle(1'b0);
    beats32();
    check_eq("check_crc32", crc32, 32'hCBF43926);
    check_eq("check_mpeg2", crcM, 32'h0376E6E7);
    drain32(2, 1'b0);

    // empty frame
    frame_q.delete();
    start32_cycle(1'b0);
    beats32();
    check_eq("empty_crc32", crc32, 32'h00000000);
    drain32(0, 1'b0);

    // byte-wide engine, gaps, result held for 5 cycles
    set_check_frame();
    start8_cycle();
    beats8();
    check_eq("check_crc8", crc8, 32'hCBF43926);
    drain8(5);
    frame_q.delete();
    start8_cycle();
    beats8();
    check_eq("empty_crc8", crc8, 32'h00000000);
    drain8(1);

    // rst mid-frame, then full restart
    set_check_frame();
    start32_cycle(1'b0);
    partial32(2);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_ov32", 32'(outValid32), 32'd0);
    check_eq("rst_mid_busy32", 32'(busy32), 32'd0);
    check_eq("rst_mid_crc32", crc32, 32'd0);
    check_eq("rst_mid_rdy32", 32'(inReady32), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    start32_cycle(1'b0);
    beats32();
    check_eq("restart_crc32", crc32, 32'hCBF43926);
    drain32(1, 1'b0);

    // start mid-frame with a colliding beat discards the partial CRC
    start32_cycle(1'b0);
    partial32(2);
    start32_cycle(1'b1);
    beats32();
    check_eq("restart_start_crc32", crc32, 32'hCBF43926);
    // outReady + start together: straight into RUN, back-to-back frame
    drain32(0, 1'b1);
    set_random_frame(16);
    beats32();
    drain32(1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      set_random_frame(21);
      start32_cycle(1'b0);
      beats32();
      drain32($urandom_range(0, 3), 1'($urandom));
      if (busy32) begin
        set_random_frame(9);
        beats32();
        drain32(0, 1'b0);
      end
      set_random_frame(12);
      start8_cycle();
      beats8();
      drain8($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
